// File: rtl/mario_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mario_motion_ctrl_if
// Description : Keyboard/collision inputs and motion outputs of mario_motion_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface mario_motion_ctrl_if;
  logic [31:0] keycode;
  logic        hit_ground;
  logic        hit_ceiling;
  logic        jump_busy;
  logic        jump_en;
  logic        jump_cancel;
  logic [9:0]  x_motion;
  logic [9:0]  fall_motion;
  logic        airborne;
  logic        facing_left;

  modport master (
    output keycode, hit_ground, hit_ceiling, jump_busy,
    input  jump_en, jump_cancel, x_motion, fall_motion, airborne, facing_left
  );

  modport slave (
    input  keycode, hit_ground, hit_ceiling, jump_busy,
    output jump_en, jump_cancel, x_motion, fall_motion, airborne, facing_left
  );
endinterface
`default_nettype wire

// File: rtl/mario_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mario_motion_ctrl
// Description : Per-frame jump/fall state machine and horizontal speed ramp.
// Revision    : 1.0 - initial release
// ============================================================================
module mario_motion_ctrl (
  input  logic                frame_clk,
  input  logic                Reset,
  mario_motion_ctrl_if.slave  bus
);

  localparam logic [7:0] KEY_LEFT   = 8'h04;
  localparam logic [7:0] KEY_RIGHT  = 8'h07;
  localparam logic [7:0] KEY_JUMP_A = 8'h1A;
  localparam logic [7:0] KEY_JUMP_B = 8'h2C;
  localparam logic [2:0] SPEED_MAX  = 3'd4;
  localparam logic [9:0] FALL_MAX   = 10'd8;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    LAUNCH   = 2'd1,
    RISING   = 2'd2,
    FALLING  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       left_held;
  logic       right_held;
  logic       jump_held;
  logic       jump_prev;
  logic       jump_press;
  logic       left_only;
  logic       right_only;
  logic       jump_en_next;
  logic       jump_cancel_next;
  logic [9:0] fall_next;
  logic [2:0] speed;
  logic [2:0] speed_next;
  logic       speed_left;
  logic       speed_left_next;
  logic [9:0] x_next;
  logic       facing_next;

  always_comb begin
    left_held  = 1'b0;
    right_held = 1'b0;
    jump_held  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.keycode[i*8 +: 8] == KEY_LEFT)   left_held  = 1'b1;
      if (bus.keycode[i*8 +: 8] == KEY_RIGHT)  right_held = 1'b1;
      if (bus.keycode[i*8 +: 8] == KEY_JUMP_A) jump_held  = 1'b1;
      if (bus.keycode[i*8 +: 8] == KEY_JUMP_B) jump_held  = 1'b1;
    end
  end

  assign jump_press = jump_held & ~jump_prev;
  assign left_only  = left_held & ~right_held;
  assign right_only = right_held & ~left_held;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state <= GROUNDED;
    else       state <= state_next;
  end

  // Ground loss beats a jump press; a ceiling hit beats jump completion.
  always_comb begin
    state_next       = state;
    jump_cancel_next = 1'b0;
    case (state)
      GROUNDED: begin
        if (!bus.hit_ground)  state_next = FALLING;
        else if (jump_press)  state_next = LAUNCH;
      end
      LAUNCH:   state_next = RISING;
      RISING: begin
        if (bus.hit_ceiling) begin
          state_next       = FALLING;
          jump_cancel_next = 1'b1;
        end else if (!bus.jump_busy) begin
          state_next       = FALLING;
        end
      end
      FALLING: begin
        if (bus.hit_ground)   state_next = GROUNDED;
      end
      default:  state_next = GROUNDED;
    endcase

    jump_en_next = (state_next == LAUNCH);

    if (state_next != FALLING)           fall_next = 10'd0;
    else if (state != FALLING)           fall_next = 10'd1;
    else if (bus.fall_motion >= FALL_MAX) fall_next = FALL_MAX;
    else                                 fall_next = bus.fall_motion + 10'd1;
  end

  // Speed builds only while pushing along the current sign (or from rest).
  always_comb begin
    speed_next      = speed;
    speed_left_next = speed_left;
    if (left_only && (speed_left || speed == 3'd0)) begin
      speed_next      = (speed == SPEED_MAX) ? SPEED_MAX : speed + 3'd1;
      speed_left_next = 1'b1;
    end else if (right_only && (!speed_left || speed == 3'd0)) begin
      speed_next      = (speed == SPEED_MAX) ? SPEED_MAX : speed + 3'd1;
      speed_left_next = 1'b0;
    end else if (speed != 3'd0) begin
      speed_next      = speed - 3'd1;
    end

    x_next = speed_left_next ? (10'd0 - {7'd0, speed_next}) : {7'd0, speed_next};

    facing_next = bus.facing_left;
    if (left_only)       facing_next = 1'b1;
    else if (right_only) facing_next = 1'b0;
  end

  // jump_prev resets high so a key held through reset is not a press.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      jump_prev       <= 1'b1;
      speed           <= 3'd0;
      speed_left      <= 1'b0;
      bus.jump_en     <= 1'b0;
      bus.jump_cancel <= 1'b0;
      bus.x_motion    <= 10'd0;
      bus.fall_motion <= 10'd0;
      bus.airborne    <= 1'b0;
      bus.facing_left <= 1'b0;
    end else begin
      jump_prev       <= jump_held;
      speed           <= speed_next;
      speed_left      <= speed_left_next;
      bus.jump_en     <= jump_en_next;
      bus.jump_cancel <= jump_cancel_next;
      bus.x_motion    <= x_next;
      bus.fall_motion <= fall_next;
      bus.airborne    <= (state_next != GROUNDED);
      bus.facing_left <= facing_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mario_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mario_motion_ctrl
// Description : Directed bench for mario_motion_ctrl with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mario_motion_ctrl;

  logic frame_clk;
  logic Reset;
  int   total;
  int   passed;
  int   jcount;
  int   busy_cnt;

  mario_motion_ctrl_if bus ();

  mario_motion_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus.slave)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                tag, $signed(obs), obs, $signed(exp), exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".jump_en"},     {9'd0, bus.jump_en},     10'd0);
    check({tag, ".jump_cancel"}, {9'd0, bus.jump_cancel}, 10'd0);
    check({tag, ".airborne"},    {9'd0, bus.airborne},    10'd0);
    check({tag, ".facing_left"}, {9'd0, bus.facing_left}, 10'd0);
    check({tag, ".x_motion"},    bus.x_motion,            10'd0);
    check({tag, ".fall_motion"}, bus.fall_motion,         10'd0);
  endtask

  initial begin
    total           = 0;
    passed          = 0;
    Reset           = 1'b1;
    bus.keycode     = 32'h0;
    bus.hit_ground  = 1'b1;
    bus.hit_ceiling = 1'b0;
    bus.jump_busy   = 1'b0;
    step();
    step();
    check_all_zero("reset");
    Reset = 1'b0;
    step();
    check_all_zero("post_reset");

    // Single-frame jump tap; ground stays high to show RISING ignores it.
    bus.keycode = 32'h0000002C;
    step();
    check("tap.jump_en", {9'd0, bus.jump_en}, 10'd1);
    check("tap.airborne", {9'd0, bus.airborne}, 10'd1);
    bus.keycode   = 32'h0;
    bus.jump_busy = 1'b1;
    step();
    check("tap.jump_en_once", {9'd0, bus.jump_en}, 10'd0);
    step();
    step();
    check("rise.airborne", {9'd0, bus.airborne}, 10'd1);
    check("rise.fall", bus.fall_motion, 10'd0);
    bus.jump_busy = 1'b0;
    step();
    check("busy_done.fall", bus.fall_motion, 10'd1);
    check("busy_done.airborne", {9'd0, bus.airborne}, 10'd1);
    step();
    check("land.fall", bus.fall_motion, 10'd0);
    check("land.airborne", {9'd0, bus.airborne}, 10'd0);

    // Held key for 40 frames: busy 20 frames, landing at frame 30.
    jcount   = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      bus.keycode    = 32'h0000002C;
      bus.hit_ground = (i == 0) || (i >= 30);
      bus.jump_busy  = (busy_cnt > 0);
      step();
      if (bus.jump_en) begin
        jcount++;
        busy_cnt = 20;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
    end
    check("hold40.jump_count", jcount[9:0], 10'd1);
    check("hold40.airborne", {9'd0, bus.airborne}, 10'd0);
    bus.keycode = 32'h0;
    step();
    check("release.jump_en", {9'd0, bus.jump_en}, 10'd0);
    bus.keycode = 32'h1A000000;
    step();
    check("repress.jump_en", {9'd0, bus.jump_en}, 10'd1);

    // Ceiling hit while rising.
    bus.keycode   = 32'h0;
    bus.jump_busy = 1'b1;
    step();
    bus.hit_ceiling = 1'b1;
    step();
    check("ceil.jump_cancel", {9'd0, bus.jump_cancel}, 10'd1);
    check("ceil.jump_en", {9'd0, bus.jump_en}, 10'd0);
    check("ceil.fall", bus.fall_motion, 10'd1);
    bus.hit_ceiling = 1'b0;
    bus.jump_busy   = 1'b0;
    bus.hit_ground  = 1'b0;
    step();
    check("ceil.cancel_once", {9'd0, bus.jump_cancel}, 10'd0);
    check("ceil.fall2", bus.fall_motion, 10'd2);
    bus.keycode = 32'h0000002C;
    step();
    check("fall.press_ignored", {9'd0, bus.jump_en}, 10'd0);
    check("fall.fall3", bus.fall_motion, 10'd3);
    bus.keycode    = 32'h0;
    bus.hit_ground = 1'b1;
    step();
    check("fall.land", bus.fall_motion, 10'd0);
    step();
    check("fall.no_buffered_jump", {9'd0, bus.jump_en}, 10'd0);

    // Walk off a ledge: gravity ramp saturates at 8.
    bus.hit_ground = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      check($sformatf("ledge.fall[%0d]", i), bus.fall_motion, (i < 8) ? 10'(i + 1) : 10'd8);
    end
    bus.hit_ground = 1'b1;
    step();
    check("ledge.land_fall", bus.fall_motion, 10'd0);
    check("ledge.land_airborne", {9'd0, bus.airborne}, 10'd0);

    // Right for 6 frames then left, keys placed in different slots.
    bus.keycode = 32'h00070000;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("right.x[%0d]", i), bus.x_motion, (i < 4) ? 10'(i + 1) : 10'd4);
    end
    check("right.facing", {9'd0, bus.facing_left}, 10'd0);
    bus.keycode = 32'h04000000;
    step();
    check("left.facing_first", {9'd0, bus.facing_left}, 10'd1);
    check("left.x[0]", bus.x_motion, 10'd3);
    step();
    check("left.x[1]", bus.x_motion, 10'd2);
    step();
    check("left.x[2]", bus.x_motion, 10'd1);
    step();
    check("left.x[3]", bus.x_motion, 10'd0);
    step();
    check("left.x[4]", bus.x_motion, 10'h3FF);
    step();
    check("left.x[5]", bus.x_motion, 10'h3FE);
    bus.keycode = 32'h00000407;
    step();
    check("both.x", bus.x_motion, 10'h3FF);
    check("both.facing_hold", {9'd0, bus.facing_left}, 10'd1);
    bus.keycode = 32'h0;
    step();
    check("none.x", bus.x_motion, 10'd0);

    // Reset mid-fall with jump held.
    bus.keycode    = 32'h0000002C;
    bus.hit_ground = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("prereset.fall", bus.fall_motion, 10'd5);
    check("prereset.airborne", {9'd0, bus.airborne}, 10'd1);
    Reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    bus.hit_ground = 1'b1;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("held_after_reset.jump_en[%0d]", i), {9'd0, bus.jump_en}, 10'd0);
    end
    check("held_after_reset.airborne", {9'd0, bus.airborne}, 10'd0);
    bus.keycode = 32'h0;
    step();
    bus.keycode = 32'h0000002C;
    step();
    check("after_reset.repress", {9'd0, bus.jump_en}, 10'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mario_motion_ctrl.md
MARIO_MOTION_CTRL -- requirements
Module: mario_motion_ctrl

Interface
REQ-001 The block SHALL have `frame_clk`, input, 1 bit: the frame-rate clock, with all state updated on its rising edge.
REQ-002 The block SHALL have `Reset`, input, 1 bit: asynchronous, active-high reset; clock is `frame_clk`.
REQ-003 The block SHALL have `keycode`, input, 32 bits: four USB HID key codes, byte0 = [7:0] through byte3 = [31:24]; 0x00 = empty slot.
REQ-004 The block SHALL have `hit_ground`, input, 1 bit: the character's feet rest on a solid surface this frame.
REQ-005 The block SHALL have `hit_ceiling`, input, 1 bit: the character's head touches a solid surface this frame.
REQ-006 The block SHALL have `jump_busy`, input, 1 bit: the jump-profile FSM is outside its idle state.
REQ-007 The block SHALL have `jump_en`, output, 1 bit: one-frame request to the jump-profile FSM to start a jump.
REQ-008 The block SHALL have `jump_cancel`, output, 1 bit: one-frame abort to the jump-profile FSM, ORed at top level into its ground input.
REQ-009 The block SHALL have `x_motion`, output, 10 bits: signed two's-complement horizontal velocity in px/frame.
REQ-010 The block SHALL have `fall_motion`, output, 10 bits: signed gravity velocity in px/frame; positive = down.
REQ-011 The block SHALL have `airborne`, output, 1 bit: high when the state is not GROUNDED.
REQ-012 The block SHALL have `facing_left`, output, 1 bit: sprite orientation.

Function
REQ-013 A key SHALL count as held when any of the 4 keycode bytes equals its code: left = 0x04, right = 0x07, jump = 0x1A or 0x2C.
REQ-014 The block SHALL register the jump-held value each frame (`jump_prev`); a jump press SHALL mean jump held AND NOT `jump_prev`.
REQ-015 The state machine SHALL have exactly four states: GROUNDED, LAUNCH, RISING, FALLING; all outputs SHALL be registered.
REQ-016 GROUNDED SHALL go to FALLING when `hit_ground` = 0; otherwise it SHALL go to LAUNCH on a jump press; otherwise it SHALL remain in GROUNDED. Loss of ground SHALL take priority over a jump press.
REQ-017 LAUNCH SHALL drive `jump_en` = 1 for exactly one frame, then go to RISING unconditionally.
REQ-018 RISING SHALL ignore `hit_ground`. On `hit_ceiling` = 1 it SHALL go to FALLING and drive `jump_cancel` = 1 for that one frame.
REQ-019 RISING SHALL go to FALLING when `jump_busy` = 0, evaluated only after at least one frame in RISING. A ceiling hit and jump completion in the same frame SHALL act as a ceiling hit.
REQ-020 `fall_motion` SHALL be 0 in GROUNDED, LAUNCH and RISING. On entry to FALLING it SHALL be +1, then increment by 1 per frame, saturating at +8.
REQ-021 FALLING SHALL go to GROUNDED on `hit_ground` = 1 and clear `fall_motion` to 0 on the same edge. Jump presses in FALLING SHALL be ignored, with no buffering.
REQ-022 The speed magnitude (0..4) SHALL update once per frame:
- exactly one direction held and matching the current sign, or speed = 0: +1, saturating at 4, and the sign takes that direction;
- opposite direction held, both held, or neither held: -1 toward 0.
REQ-023 `x_motion` SHALL equal the sign applied to the magnitude (left = negative): range -4..+4, sign-extended to 10 bits. Ramp behaviour SHALL be identical when airborne.
REQ-024 `facing_left` SHALL update only when exactly one of left/right is held; otherwise it SHALL hold its value.
REQ-025 `jump_en` and `jump_cancel` SHALL never both be 1 in the same frame.

Reset
REQ-026 Reset SHALL force: state = GROUNDED; `jump_en` = `jump_cancel` = `airborne` = `facing_left` = 0; `x_motion` = `fall_motion` = 0; speed = 0; `jump_prev` = 1.
REQ-027 A jump key held through reset release SHALL NOT start a jump.
REQ-028 Reset asserted mid-jump or mid-fall SHALL apply REQ-026 immediately, without waiting for a clock edge.

Verification
REQ-029 Grounded, keycode = 0x0000002C for 1 frame -> `jump_en` = 1 exactly one frame later for 1 frame; `airborne` = 1 until `hit_ground`.
REQ-030 Jump key held for 40 frames, with `jump_busy` modelled as 20 frames and landing at frame 30 -> exactly one `jump_en`; no second jump after landing until the key is released and re-pressed.
REQ-031 `hit_ground` dropped while grounded -> `fall_motion` sequence 1,2,...,8,8,8; `hit_ground` = 1 -> 0 on the next frame.
REQ-032 RISING with `hit_ceiling` = 1 -> one-frame `jump_cancel`, state = FALLING, `fall_motion` = 1.
REQ-033 Right held 6 frames, then left held -> `x_motion` = 1,2,3,4,4,4 then 3,2,1,0,-1,-2; `facing_left` = 1 from the first left frame.
REQ-034 Reset pulsed during FALLING with `fall_motion` = 5 and the jump key held -> all outputs 0 immediately; no `jump_en` after release until the key is re-pressed.
